hwpe_sel_ctrl: RTL and testbench

// - Upstream controller for the HWPE subsystem. It drives the subsystem's HWPE select and clock-enable inputs.
// - Changes the selected HWPE only when it is safe to do so:
//   - cfg-bus traffic is blocked;
//   - outstanding cfg responses and the busy HWPE are drained;
//   - the HWPE clock is gated for a settle window;
//   - the select changes while the clock is gated.
// - The static TCDM mux and the cfg demux therefore never see the select change mid-transaction.

---
 rtl/hwpe_sel_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hwpe_sel_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hwpe_sel_ctrl.sv
// Upstream select/clock-enable controller for the HWPE subsystem: a select change
// happens only after cfg traffic is blocked and drained, the HWPE is idle, and its clock has settled off.
module hwpe_sel_ctrl #(
  parameter int unsigned N_HWPES         = 2,
  parameter int unsigned DEFAULT_SEL     = 0,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SW              = (N_HWPES > 1) ? $clog2(N_HWPES) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hwpe_en_req_i,
  input  logic          sel_req_i,
  input  logic [SW-1:0] sel_i,
  output logic          sel_gnt_o,
  output logic          sel_err_o,
  input  logic          busy_i,
  input  logic          cfg_req_i,
  input  logic          cfg_gnt_i,
  input  logic          cfg_r_valid_i,
  output logic          cfg_block_o,
  output logic [SW-1:0] hwpe_sel_o,
  output logic          hwpe_en_o
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SL  = SETTLE_CYCLES - 1;

  localparam logic [SW:0]    N_EXT       = N_HWPES[SW:0];
  localparam logic [SW-1:0]  DEF_SEL     = DEFAULT_SEL[SW-1:0];
  localparam logic [CW-1:0]  MAX_CNT     = MAX_OUTSTANDING[CW-1:0];
  localparam logic [STW-1:0] SETTLE_LOAD = SL[STW-1:0];

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    GATE   = 2'd2,
    SWITCH = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  target_q, target_d;
  logic [STW-1:0] settle_q, settle_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [SW-1:0]  hwpe_sel_q, hwpe_sel_d;
  logic           hwpe_en_q, hwpe_en_d;
  logic           sel_gnt_q, sel_gnt_d;
  logic           sel_err_q, sel_err_d;
  logic           cfg_block_q, cfg_block_d;

  logic           sel_invalid_s;
  logic           cnt_inc_s;
  logic           cnt_dec_s;

  assign sel_invalid_s = ({1'b0, sel_i} >= N_EXT);
  assign cnt_inc_s     = cfg_req_i & cfg_gnt_i;
  assign cnt_dec_s     = cfg_r_valid_i;

  // Outstanding cfg counter: saturates at both ends, simultaneous inc/dec cancels.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc_s && cnt_dec_s) begin
      cnt_d = cnt_q;
    end else if (cnt_inc_s && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (cnt_dec_s && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    settle_d  = settle_q;
    sel_gnt_d = 1'b0;
    sel_err_d = 1'b0;
    case (state_q)
      RUN: begin
        if (sel_req_i) begin
          if (sel_invalid_s) begin
            sel_err_d = 1'b1;
          end else if (sel_i == hwpe_sel_q) begin
            sel_gnt_d = 1'b1;
          end else begin
            target_d = sel_i;
            state_d  = DRAIN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!busy_i && (cnt_q == {CW{1'b0}})) begin
          state_d  = GATE;
          settle_d = SETTLE_LOAD;
        end else begin
          state_d = DRAIN;
        end
      end
      GATE: begin
        if (settle_q == {STW{1'b0}}) begin
          state_d = SWITCH;
        end else begin
          settle_d = settle_q - {{(STW-1){1'b0}}, 1'b1};
        end
      end
      SWITCH: begin
        state_d   = RUN;
        sel_gnt_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    hwpe_sel_d  = hwpe_sel_q;
    hwpe_en_d   = 1'b0;
    cfg_block_d = (state_d != RUN) | (cnt_d == MAX_CNT);
    if ((state_d == RUN) || (state_d == DRAIN)) begin
      hwpe_en_d = hwpe_en_req_i;
    end else begin
      hwpe_en_d = 1'b0;
    end
    if (state_d == SWITCH) begin
      hwpe_sel_d = target_q;
    end else begin
      hwpe_sel_d = hwpe_sel_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      target_q <= DEF_SEL;
      settle_q <= {STW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hwpe_sel_q  <= DEF_SEL;
      hwpe_en_q   <= 1'b0;
      sel_gnt_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      cfg_block_q <= 1'b0;
    end else begin
      hwpe_sel_q  <= hwpe_sel_d;
      hwpe_en_q   <= hwpe_en_d;
      sel_gnt_q   <= sel_gnt_d;
      sel_err_q   <= sel_err_d;
      cfg_block_q <= cfg_block_d;
    end
  end

  assign hwpe_sel_o  = hwpe_sel_q;
  assign hwpe_en_o   = hwpe_en_q;
  assign sel_gnt_o   = sel_gnt_q;
  assign sel_err_o   = sel_err_q;
  assign cfg_block_o = cfg_block_q;

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
// Directed bench for hwpe_sel_ctrl; three HWPEs so that an out-of-range index (3) is encodable.
module tb_hwpe_sel_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          hwpe_en_req;
  logic          sel_req;
  logic [SW-1:0] sel;
  logic          sel_gnt;
  logic          sel_err;
  logic          busy;
  logic          cfg_req;
  logic          cfg_gnt;
  logic          cfg_r_valid;
  logic          cfg_block;
  logic [SW-1:0] hwpe_sel;
  logic          hwpe_en;

  int checks = 0;
  int errors = 0;

  hwpe_sel_ctrl #(
    .N_HWPES(N), .DEFAULT_SEL(0), .SETTLE_CYCLES(2), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hwpe_en_req_i(hwpe_en_req),
    .sel_req_i(sel_req), .sel_i(sel), .sel_gnt_o(sel_gnt), .sel_err_o(sel_err),
    .busy_i(busy), .cfg_req_i(cfg_req), .cfg_gnt_i(cfg_gnt),
    .cfg_r_valid_i(cfg_r_valid), .cfg_block_o(cfg_block),
    .hwpe_sel_o(hwpe_sel), .hwpe_en_o(hwpe_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [SW-1:0] e_sel, input logic e_en,
                         input logic e_blk, input logic e_gnt, input logic e_err);
    chk({tag, ".sel"}, 32'(hwpe_sel), 32'(e_sel));
    chk({tag, ".en"},  32'(hwpe_en),  32'(e_en));
    chk({tag, ".blk"}, 32'(cfg_block), 32'(e_blk));
    chk({tag, ".gnt"}, 32'(sel_gnt),  32'(e_gnt));
    chk({tag, ".err"}, 32'(sel_err),  32'(e_err));
  endtask

  initial begin
    rst = 1'b1; hwpe_en_req = 1'b1; sel_req = 1'b0; sel = 2'd0; busy = 1'b0;
    cfg_req = 1'b0; cfg_gnt = 1'b0; cfg_r_valid = 1'b0;

    // reset held three cycles, enable request already high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    tick();
    chk_all("rst_rel", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // idle switch 0 -> 1
    sel_req = 1'b1; sel = 2'd1;
    tick(); sel_req = 1'b0;
    chk_all("sw_t1", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("sw_t2", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("sw_t3", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("sw_t4", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("sw_t5", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("sw_t6", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // same select: immediate grant, no gating
    sel_req = 1'b1; sel = 2'd1;
    tick(); sel_req = 1'b0;
    chk_all("same", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("same_n", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // out-of-range select
    sel_req = 1'b1; sel = 2'd3;
    tick(); sel_req = 1'b0;
    chk_all("err", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("err_n", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // busy drain: two outstanding cfg transactions, busy for 10 cycles
    cfg_req = 1'b1; cfg_gnt = 1'b1;
    tick(); tick();
    cfg_req = 1'b0; cfg_gnt = 1'b0;
    chk("out2.blk", 32'(cfg_block), 32'd0);
    busy = 1'b1; sel_req = 1'b1; sel = 2'd0;
    tick(); sel_req = 1'b0;
    chk_all("drn_t1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_all("drn_busy", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    busy = 1'b0;
    tick(); chk_all("drn_cnt2", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("drn_cnt2b", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cfg_r_valid = 1'b1;
    tick(); chk_all("drn_rv1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); cfg_r_valid = 1'b0;
    chk_all("drn_rv2", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("drn_g1", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("drn_g2", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("drn_sw", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("drn_run", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // counter boundaries
    cfg_r_valid = 1'b1;
    tick(); cfg_r_valid = 1'b0;
    chk("rv_at0.blk", 32'(cfg_block), 32'd0);
    cfg_req = 1'b1; cfg_gnt = 1'b1;
    tick(); tick(); tick();
    chk("cnt3.blk", 32'(cfg_block), 32'd0);
    tick();
    chk("cnt4.blk", 32'(cfg_block), 32'd1);
    cfg_req = 1'b0; cfg_gnt = 1'b0; cfg_r_valid = 1'b1;
    tick();
    chk("cnt4to3.blk", 32'(cfg_block), 32'd0);
    cfg_req = 1'b1; cfg_gnt = 1'b1;
    tick();
    chk("both.blk", 32'(cfg_block), 32'd0);
    cfg_r_valid = 1'b0;
    tick();
    chk("cnt4b.blk", 32'(cfg_block), 32'd1);
    tick();
    chk("sat.blk", 32'(cfg_block), 32'd1);
    cfg_req = 1'b0; cfg_gnt = 1'b0; cfg_r_valid = 1'b1;
    tick();
    chk("sat_dec.blk", 32'(cfg_block), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_cnt.blk", 32'(cfg_block), 32'd0);
    end
    cfg_r_valid = 1'b0;

    // switch to 2 so the default select is distinguishable after reset
    sel_req = 1'b1; sel = 2'd2;
    tick(); sel_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk_all("sw2", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);

    // reset during GATE aborts the switch
    sel_req = 1'b1; sel = 2'd1;
    tick(); sel_req = 1'b0;
    tick();
    chk_all("gate", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("gate_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("gate_rel", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("gate_post", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
